fpu_issue_station: RTL and testbench
====================================

// Module: fpu_issue_station
// PURPOSE
//  Reservation station directly upstream of the FPU execution unit. It buffers
//  up to DEPTH dispatched FPU ops and snoops two result buses for missing source
//  operands. Each cycle it issues the oldest op whose operands are both present
//  onto the unit's ds_val/dt_val/dd/imm/ctrl inputs. ctrl=4'b0000 with dd=0 is
//  the NOP encoding the unit ignores.
// PARAMETERS
//  DEPTH  4  number of entries (>=2)
//  CW     $clog2(DEPTH+1)  width of rs_count
// PORTS
//  clk         in   1   clock
//  rstn        in   1   synchronous, active-low reset
//  flush       in   1   discard all entries (mispredict)
//  disp_valid  in   1   dispatch request this cycle
//  disp_ctrl   in   4   op code passed through to unit
//  disp_dd     in   6   destination tag
//  disp_imm    in   16  immediate, passed through
//  disp_s_tag  in   6   source-s producer tag; 0 = disp_s_val already valid
//  disp_s_val  in   32  source-s value, used when disp_s_tag==0
//  disp_t_tag  in   6   source-t producer tag; 0 = disp_t_val already valid
//  disp_t_val  in   32  source-t value, used when disp_t_tag==0
//  cdb0_tag    in   6   result bus 0 tag; 0 = no broadcast
//  cdb0_val    in   32  result bus 0 value
//  cdb1_tag    in   6   result bus 1 tag; 0 = no broadcast
//  cdb1_val    in   32  result bus 1 value
//  fu_busy     in   1   unit cannot accept an op this cycle
//  rs_full     out  1   count==DEPTH; dispatch must stall
//  rs_count    out  CW  occupied entries
//  iss_valid   out  1   issue registers hold a real op
//  iss_ctrl    out  4   to unit ctrl
//  iss_dd      out  6   to unit dd
//  iss_imm     out  16  to unit imm
//  iss_ds_val  out  32  to unit ds_val
//  iss_dt_val  out  32  to unit dt_val
// BEHAVIOUR
//  - Reset (rstn=0 at clk edge): all entries invalid. rs_count=0, rs_full=0.
//    iss_valid=0 and every iss_* output=0.
//  - Storage: age-ordered compacting queue, with entry 0 oldest. Each entry holds
//    ctrl, dd, imm, and per source {tag, val, rdy}. rdy=1 iff the stored tag is
//    0 or the tag was captured from a result bus.
//  - Dispatch: accepted iff disp_valid && !rs_full, with rs_full taken from the
//    registered count. disp_valid while full is dropped; a bench flags it as an
//    error. The new op is written behind the entries that remain after this
//    cycle's issue.
//  - Wakeup: every cycle, each waiting source whose tag equals a nonzero cdbN_tag
//    latches cdbN_val and sets rdy. If both buses match, cdb0 wins. A dispatching
//    source whose tag matches a bus in the same cycle is captured ready at write.
//  - Select: combinational over the registered rdy bits. The issuer is the
//    lowest-index entry with both rdy=1. An op that wakes in cycle t is
//    selectable no earlier than cycle t+1.
//  - Issue: when an entry is selected and fu_busy=0, the entry's fields are
//    registered onto iss_* with iss_valid=1. The entry is removed and younger
//    entries shift down by one.
//  - No issue: when nothing is selected or fu_busy=1, iss_valid=0, iss_ctrl=0
//    and iss_dd=0 (NOP). iss_ds_val, iss_dt_val and iss_imm hold their values.
//  - Latency: an op dispatched with both sources ready at edge t appears on
//    iss_* after edge t+1, so the minimum dispatch-to-issue time is 2 cycles.
//  - rs_count next = count + accepted dispatch - issue. Simultaneous dispatch
//    and issue leaves it unchanged. Dispatch while full is not accepted even if
//    an issue occurs in the same cycle.
//  - Flush: has priority over dispatch, wakeup and issue. Next cycle: all
//    entries invalid, count=0, iss_valid=0, iss_ctrl=0, iss_dd=0. Same for
//    reset asserted mid-operation.
//  - Tags and values are never modified beyond the capture rules above. ctrl
//    is passed through opaque, with no arithmetic.
// TESTING
//  - Reset: hold rstn=0 for 2 cycles -> rs_count=0, rs_full=0, iss_valid=0,
//    all iss_*=0.
//  - Ready dispatch: disp ctrl=3, dd=5, s_tag=0/s_val=7, t_tag=0/t_val=9 ->
//    two cycles later iss_valid=1, ctrl=3, dd=5, ds=7, dt=9; rs_count back to 0.
//  - Wakeup: dispatch with s_tag=12 (others ready), then cdb1_tag=12 with
//    cdb1_val=0xDEAD, then cdb0_tag=12 with cdb0_val=0x1 in a later cycle ->
//    issues with ds=0xDEAD. The same tag on both buses in one cycle takes cdb0.
//  - Ordering/full: fill 4 entries, oldest waiting, the others ready ->
//    rs_full=1. Further disp_valid is dropped. Ready entries issue in age order.
//    After the waiter wakes it issues next; count goes 4->3->2->1->0.
//  - fu_busy: keep fu_busy=1 for 3 cycles with a ready op -> iss_valid=0 and
//    iss_ctrl=0 throughout, then the op issues on the cycle after fu_busy=0.
//  - Flush: 3 entries held plus a simultaneous dispatch and flush -> next cycle
//    rs_count=0, iss_valid=0, and no op issues afterward.

Source files
------------

// File: rtl/fpu_issue_station.sv
// fpu_issue_station: reservation station feeding the FPU execution unit.
// Age-ordered compacting queue with two-bus operand wakeup and oldest-first issue.
module fpu_issue_station #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          disp_valid,
  input  logic [3:0]    disp_ctrl,
  input  logic [5:0]    disp_dd,
  input  logic [15:0]   disp_imm,
  input  logic [5:0]    disp_s_tag,
  input  logic [31:0]   disp_s_val,
  input  logic [5:0]    disp_t_tag,
  input  logic [31:0]   disp_t_val,
  input  logic [5:0]    cdb0_tag,
  input  logic [31:0]   cdb0_val,
  input  logic [5:0]    cdb1_tag,
  input  logic [31:0]   cdb1_val,
  input  logic          fu_busy,
  output logic          rs_full,
  output logic [CW-1:0] rs_count,
  output logic          iss_valid,
  output logic [3:0]    iss_ctrl,
  output logic [5:0]    iss_dd,
  output logic [15:0]   iss_imm,
  output logic [31:0]   iss_ds_val,
  output logic [31:0]   iss_dt_val
);

  localparam int            IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic        vld;
    logic [3:0]  ctrl;
    logic [5:0]  dd;
    logic [15:0] imm;
    logic [5:0]  s_tag;
    logic [31:0] s_val;
    logic        s_rdy;
    logic [5:0]  t_tag;
    logic [31:0] t_val;
    logic        t_rdy;
  } ent_t;

  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  ent_t          wk    [DEPTH];
  ent_t          new_e;
  logic [CW-1:0] cnt_q, cnt_d, wr_idx;
  logic          sel_vld;
  logic [IW-1:0] sel_idx;
  logic          do_iss, acc;

  logic          iss_valid_q;
  logic [3:0]    iss_ctrl_q;
  logic [5:0]    iss_dd_q;
  logic [15:0]   iss_imm_q;
  logic [31:0]   iss_ds_q, iss_dt_q;

  // Snoop both buses for one source; cdb0 takes priority when both match.
  function automatic logic [32:0] grab(
    input logic        rdy,
    input logic [5:0]  tag,
    input logic [31:0] val,
    input logic [5:0]  t0,
    input logic [31:0] v0,
    input logic [5:0]  t1,
    input logic [31:0] v1
  );
    logic [32:0] r;
    r = {rdy, val};
    if (!rdy) begin
      if (t0 != '0 && t0 == tag)      r = {1'b1, v0};
      else if (t1 != '0 && t1 == tag) r = {1'b1, v1};
    end
    return r;
  endfunction

  assign rs_full  = (cnt_q == FULL);
  assign rs_count = cnt_q;
  assign acc      = disp_valid && !rs_full;
  assign do_iss   = sel_vld && !fu_busy;
  assign wr_idx   = cnt_q - CW'(do_iss);

  // Build the incoming entry, capturing any operand broadcast this cycle.
  always_comb begin
    new_e       = '0;
    new_e.vld   = 1'b1;
    new_e.ctrl  = disp_ctrl;
    new_e.dd    = disp_dd;
    new_e.imm   = disp_imm;
    new_e.s_tag = disp_s_tag;
    new_e.t_tag = disp_t_tag;
    {new_e.s_rdy, new_e.s_val} = grab(disp_s_tag == '0, disp_s_tag,
      disp_s_val, cdb0_tag, cdb0_val, cdb1_tag, cdb1_val);
    {new_e.t_rdy, new_e.t_val} = grab(disp_t_tag == '0, disp_t_tag,
      disp_t_val, cdb0_tag, cdb0_val, cdb1_tag, cdb1_val);
  end

  // Wake waiting sources of stored entries from the result buses.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk[i] = ent_q[i];
      {wk[i].s_rdy, wk[i].s_val} = grab(ent_q[i].s_rdy, ent_q[i].s_tag,
        ent_q[i].s_val, cdb0_tag, cdb0_val, cdb1_tag, cdb1_val);
      {wk[i].t_rdy, wk[i].t_val} = grab(ent_q[i].t_rdy, ent_q[i].t_tag,
        ent_q[i].t_val, cdb0_tag, cdb0_val, cdb1_tag, cdb1_val);
    end
  end

  // Pick the oldest entry whose registered ready bits are both set.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].vld && ent_q[i].s_rdy && ent_q[i].t_rdy) begin
        sel_vld = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  // Compact over the issued slot, then append the dispatch behind survivors.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = wk[i];
    if (do_iss) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IW'(i) >= sel_idx) ent_d[i] = wk[i+1];
      end
      ent_d[DEPTH-1].vld = 1'b0;
    end
    if (acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) ent_d[i] = new_e;
      end
    end
    cnt_d = cnt_q + CW'(acc) - CW'(do_iss);
  end

  // Queue storage and occupancy; flush drops every entry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].vld <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      cnt_q <= cnt_d;
    end
  end

  // Issue registers; idle cycles drive a NOP but keep operand/imm values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      iss_valid_q <= 1'b0;
      iss_ctrl_q  <= '0;
      iss_dd_q    <= '0;
      iss_imm_q   <= '0;
      iss_ds_q    <= '0;
      iss_dt_q    <= '0;
    end else if (flush || !do_iss) begin
      iss_valid_q <= 1'b0;
      iss_ctrl_q  <= '0;
      iss_dd_q    <= '0;
    end else begin
      iss_valid_q <= 1'b1;
      iss_ctrl_q  <= ent_q[sel_idx].ctrl;
      iss_dd_q    <= ent_q[sel_idx].dd;
      iss_imm_q   <= ent_q[sel_idx].imm;
      iss_ds_q    <= ent_q[sel_idx].s_val;
      iss_dt_q    <= ent_q[sel_idx].t_val;
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_ctrl   = iss_ctrl_q;
  assign iss_dd     = iss_dd_q;
  assign iss_imm    = iss_imm_q;
  assign iss_ds_val = iss_ds_q;
  assign iss_dt_val = iss_dt_q;

endmodule

// File: tb/tb_fpu_issue_station.sv
// tb_fpu_issue_station: table-driven directed checks of the FPU issue station.
// Each row drives one cycle of inputs and states the outputs after that edge.
module tb_fpu_issue_station;

  logic        clk = 1'b0;
  logic        rstn, flush, disp_valid, fu_busy;
  logic [3:0]  disp_ctrl;
  logic [5:0]  disp_dd, disp_s_tag, disp_t_tag, cdb0_tag, cdb1_tag;
  logic [15:0] disp_imm;
  logic [31:0] disp_s_val, disp_t_val, cdb0_val, cdb1_val;
  logic        rs_full, iss_valid;
  logic [2:0]  rs_count;
  logic [3:0]  iss_ctrl;
  logic [5:0]  iss_dd;
  logic [15:0] iss_imm;
  logic [31:0] iss_ds_val, iss_dt_val;

  always #5 clk = ~clk;

  fpu_issue_station #(.DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .disp_valid(disp_valid), .disp_ctrl(disp_ctrl),
    .disp_dd(disp_dd), .disp_imm(disp_imm),
    .disp_s_tag(disp_s_tag), .disp_s_val(disp_s_val),
    .disp_t_tag(disp_t_tag), .disp_t_val(disp_t_val),
    .cdb0_tag(cdb0_tag), .cdb0_val(cdb0_val),
    .cdb1_tag(cdb1_tag), .cdb1_val(cdb1_val),
    .fu_busy(fu_busy), .rs_full(rs_full), .rs_count(rs_count),
    .iss_valid(iss_valid), .iss_ctrl(iss_ctrl), .iss_dd(iss_dd),
    .iss_imm(iss_imm), .iss_ds_val(iss_ds_val),
    .iss_dt_val(iss_dt_val)
  );

  typedef struct {
    logic        rstn, fl, dv, fb;
    logic [3:0]  ctrl;
    logic [5:0]  dd;
    logic [15:0] imm;
    logic [5:0]  st;
    logic [31:0] sv;
    logic [5:0]  tt;
    logic [31:0] tv;
    logic [5:0]  c0t;
    logic [31:0] c0v;
    logic [5:0]  c1t;
    logic [31:0] c1v;
  } in_t;

  typedef struct {
    logic [2:0]  cnt;
    logic        full, vld;
    logic [3:0]  ctrl;
    logic [5:0]  dd;
    logic [31:0] ds, dt;
    logic [15:0] imm;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic in_t idle();
    in_t r;
    r.rstn = 1'b1; r.fl = 1'b0; r.dv = 1'b0; r.fb = 1'b0;
    r.ctrl = '0; r.dd = '0; r.imm = '0;
    r.st = '0; r.sv = '0; r.tt = '0; r.tv = '0;
    r.c0t = '0; r.c0v = '0; r.c1t = '0; r.c1v = '0;
    return r;
  endfunction

  function automatic in_t dsp(input logic [3:0] c, input logic [5:0] d,
                              input logic [15:0] m,
                              input logic [5:0] st, input logic [31:0] sv,
                              input logic [5:0] tt, input logic [31:0] tv);
    in_t r;
    r = idle();
    r.dv = 1'b1; r.ctrl = c; r.dd = d; r.imm = m;
    r.st = st; r.sv = sv; r.tt = tt; r.tv = tv;
    return r;
  endfunction

  function automatic exp_t ex(input logic [2:0] cnt, input logic vld,
                              input logic [3:0] c, input logic [5:0] d,
                              input logic [31:0] ds, input logic [31:0] dt,
                              input logic [15:0] m);
    exp_t r;
    r.cnt = cnt; r.full = (cnt == 3'd4); r.vld = vld;
    r.ctrl = c; r.dd = d; r.ds = ds; r.dt = dt; r.imm = m;
    return r;
  endfunction

  task automatic add(input in_t i, input exp_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t i);
    rstn = i.rstn; flush = i.fl; disp_valid = i.dv; fu_busy = i.fb;
    disp_ctrl = i.ctrl; disp_dd = i.dd; disp_imm = i.imm;
    disp_s_tag = i.st; disp_s_val = i.sv;
    disp_t_tag = i.tt; disp_t_val = i.tv;
    cdb0_tag = i.c0t; cdb0_val = i.c0v;
    cdb1_tag = i.c1t; cdb1_val = i.c1v;
  endtask

  task automatic check(input string nm, input exp_t e);
    n_cmp++;
    if (rs_count !== e.cnt || rs_full !== e.full) begin
      n_bad++;
      $display("FAIL %s occ: got cnt=%0d full=%0b want cnt=%0d full=%0b",
               nm, rs_count, rs_full, e.cnt, e.full);
    end
    n_cmp++;
    if (iss_valid !== e.vld || iss_ctrl !== e.ctrl || iss_dd !== e.dd ||
        iss_ds_val !== e.ds || iss_dt_val !== e.dt || iss_imm !== e.imm) begin
      n_bad++;
      $display("FAIL %s iss: got v=%0b c=%h dd=%0d ds=%h dt=%h imm=%h want v=%0b c=%h dd=%0d ds=%h dt=%h imm=%h",
               nm, iss_valid, iss_ctrl, iss_dd, iss_ds_val, iss_dt_val,
               iss_imm, e.vld, e.ctrl, e.dd, e.ds, e.dt, e.imm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t i;
    int  lat;
    bit  got;
    bit  leak;

    // reset
    i = idle(); i.rstn = 1'b0;
    add(i, ex(0, 0, 0, 0, 0, 0, 0));
    add(i, ex(0, 0, 0, 0, 0, 0, 0));
    // ready dispatch, 2-cycle latency, then NOP with held operands
    add(dsp(4'h3, 6'd5, 16'h1234, 0, 32'h7, 0, 32'h9),
        ex(1, 0, 0, 0, 0, 0, 0));
    add(idle(), ex(0, 1, 4'h3, 6'd5, 32'h7, 32'h9, 16'h1234));
    add(idle(), ex(0, 0, 0, 0, 32'h7, 32'h9, 16'h1234));
    // wakeup from cdb1; later cdb0 broadcast of same tag is ignored
    add(dsp(4'h2, 6'd6, 16'h0006, 6'd12, 32'h0, 0, 32'h20),
        ex(1, 0, 0, 0, 32'h7, 32'h9, 16'h1234));
    i = idle(); i.c1t = 6'd12; i.c1v = 32'hDEAD;
    add(i, ex(1, 0, 0, 0, 32'h7, 32'h9, 16'h1234));
    i = idle(); i.c0t = 6'd12; i.c0v = 32'h1;
    add(i, ex(0, 1, 4'h2, 6'd6, 32'hDEAD, 32'h20, 16'h0006));
    // both sources wait; both buses carry tag 13, cdb0 wins
    add(dsp(4'h4, 6'd7, 16'h0007, 6'd13, 32'h0, 6'd14, 32'h0),
        ex(1, 0, 0, 0, 32'hDEAD, 32'h20, 16'h0006));
    i = idle(); i.c0t = 6'd13; i.c0v = 32'hA0;
    i.c1t = 6'd13; i.c1v = 32'hB0;
    add(i, ex(1, 0, 0, 0, 32'hDEAD, 32'h20, 16'h0006));
    i = idle(); i.c1t = 6'd14; i.c1v = 32'hC0;
    add(i, ex(1, 0, 0, 0, 32'hDEAD, 32'h20, 16'h0006));
    add(idle(), ex(0, 1, 4'h4, 6'd7, 32'hA0, 32'hC0, 16'h0007));
    // capture at dispatch from a same-cycle broadcast
    i = dsp(4'h5, 6'd8, 16'h0008, 6'd15, 32'hFFFF, 0, 32'h33);
    i.c0t = 6'd15; i.c0v = 32'h55;
    add(i, ex(1, 0, 0, 0, 32'hA0, 32'hC0, 16'h0007));
    add(idle(), ex(0, 1, 4'h5, 6'd8, 32'h55, 32'h33, 16'h0008));
    // ordering/full: oldest waits, three ready behind it
    add(dsp(4'h1, 6'd10, 16'h000A, 6'd20, 32'h0, 0, 32'h1),
        ex(1, 0, 0, 0, 32'h55, 32'h33, 16'h0008));
    i = dsp(4'h6, 6'd11, 16'h000B, 0, 32'h11, 0, 32'h12); i.fb = 1'b1;
    add(i, ex(2, 0, 0, 0, 32'h55, 32'h33, 16'h0008));
    i = dsp(4'h7, 6'd12, 16'h000C, 0, 32'h21, 0, 32'h22); i.fb = 1'b1;
    add(i, ex(3, 0, 0, 0, 32'h55, 32'h33, 16'h0008));
    i = dsp(4'h8, 6'd13, 16'h000D, 0, 32'h31, 0, 32'h32); i.fb = 1'b1;
    add(i, ex(4, 0, 0, 0, 32'h55, 32'h33, 16'h0008));
    i = dsp(4'h9, 6'd14, 16'h000E, 0, 32'h41, 0, 32'h42); i.fb = 1'b1;
    add(i, ex(4, 0, 0, 0, 32'h55, 32'h33, 16'h0008));
    i = dsp(4'h9, 6'd14, 16'h000E, 0, 32'h41, 0, 32'h42);
    add(i, ex(3, 1, 4'h6, 6'd11, 32'h11, 32'h12, 16'h000B));
    add(idle(), ex(2, 1, 4'h7, 6'd12, 32'h21, 32'h22, 16'h000C));
    i = idle(); i.c0t = 6'd20; i.c0v = 32'h77;
    add(i, ex(1, 1, 4'h8, 6'd13, 32'h31, 32'h32, 16'h000D));
    add(idle(), ex(0, 1, 4'h1, 6'd10, 32'h77, 32'h1, 16'h000A));
    add(idle(), ex(0, 0, 0, 0, 32'h77, 32'h1, 16'h000A));
    // fu_busy holds a ready op for three cycles
    add(dsp(4'h3, 6'd20, 16'h0014, 0, 32'h40, 0, 32'h41),
        ex(1, 0, 0, 0, 32'h77, 32'h1, 16'h000A));
    i = idle(); i.fb = 1'b1;
    add(i, ex(1, 0, 0, 0, 32'h77, 32'h1, 16'h000A));
    add(i, ex(1, 0, 0, 0, 32'h77, 32'h1, 16'h000A));
    add(i, ex(1, 0, 0, 0, 32'h77, 32'h1, 16'h000A));
    add(idle(), ex(0, 1, 4'h3, 6'd20, 32'h40, 32'h41, 16'h0014));
    // flush with three held plus a simultaneous dispatch
    i = dsp(4'h1, 6'd21, 16'h0015, 0, 32'h1, 0, 32'h2); i.fb = 1'b1;
    add(i, ex(1, 0, 0, 0, 32'h40, 32'h41, 16'h0014));
    i = dsp(4'h2, 6'd22, 16'h0016, 0, 32'h3, 0, 32'h4); i.fb = 1'b1;
    add(i, ex(2, 0, 0, 0, 32'h40, 32'h41, 16'h0014));
    i = dsp(4'h3, 6'd23, 16'h0017, 0, 32'h5, 0, 32'h6); i.fb = 1'b1;
    add(i, ex(3, 0, 0, 0, 32'h40, 32'h41, 16'h0014));
    i = dsp(4'h4, 6'd24, 16'h0018, 0, 32'h7, 0, 32'h8); i.fl = 1'b1;
    add(i, ex(0, 0, 0, 0, 32'h40, 32'h41, 16'h0014));
    add(idle(), ex(0, 0, 0, 0, 32'h40, 32'h41, 16'h0014));
    add(idle(), ex(0, 0, 0, 0, 32'h40, 32'h41, 16'h0014));
    add(idle(), ex(0, 0, 0, 0, 32'h40, 32'h41, 16'h0014));
    // reset mid-operation
    add(dsp(4'h5, 6'd25, 16'h0019, 0, 32'h50, 0, 32'h51),
        ex(1, 0, 0, 0, 32'h40, 32'h41, 16'h0014));
    i = idle(); i.rstn = 1'b0;
    add(i, ex(0, 0, 0, 0, 0, 0, 0));
    add(idle(), ex(0, 0, 0, 0, 0, 0, 0));
    // simultaneous dispatch and issue keeps count
    add(dsp(4'h6, 6'd26, 16'h001A, 0, 32'h60, 0, 32'h61),
        ex(1, 0, 0, 0, 0, 0, 0));
    add(dsp(4'h7, 6'd27, 16'h001B, 0, 32'h70, 0, 32'h71),
        ex(1, 1, 4'h6, 6'd26, 32'h60, 32'h61, 16'h001A));
    add(idle(), ex(0, 1, 4'h7, 6'd27, 32'h70, 32'h71, 16'h001B));

    drive(idle());
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].i);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), tbl[k].e);
    end

    // measured dispatch-to-issue latency, bounded wait
    drive(dsp(4'hA, 6'd30, 16'hBEEF, 0, 32'h1, 0, 32'h2));
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) drive(idle());
      if (iss_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    n_cmp++;
    if (!got || lat != 2 || iss_imm !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL latency: got seen=%0b cycles=%0d imm=%h want seen=1 cycles=2 imm=beef",
               got, lat, iss_imm);
    end

    // flush two held ops, then nothing may ever issue
    i = dsp(4'hB, 6'd31, 16'h0001, 0, 32'h5, 0, 32'h6); i.fb = 1'b1;
    drive(i);
    @(posedge clk); #1;
    i = dsp(4'hC, 6'd32, 16'h0002, 0, 32'h7, 0, 32'h8); i.fb = 1'b1;
    drive(i);
    @(posedge clk); #1;
    i = idle(); i.fl = 1'b1; i.fb = 1'b1;
    drive(i);
    @(posedge clk); #1;
    drive(idle());
    leak = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (iss_valid || rs_count != 3'd0) leak = 1'b1;
    end
    n_cmp++;
    if (leak) begin
      n_bad++;
      $display("FAIL post_flush: got leak=1 want leak=0");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
